muldiv4_seq: RTL
================

// Module: muldiv4_seq
// PURPOSE
//   Sequencer that wraps the combinational 4x4 multiplier (p08_mul4) as a
//   handshaked unit. It also adds a 4-cycle iterative restoring divider.
//   It latches operands from the input interface and drives the multiplier
//   operand pins. It registers the product, or runs the divide.
//   The result is presented on a valid/ready output port for the tt_um top level.
// PARAMETERS
//   none. Operand width is fixed at 4 bits to match p08_mul4.
// PORTS
//   clk           in   1  Clock. Single clock domain; all state changes on the rising edge.
//   rst           in   1  Reset. Synchronous, active-high.
//   in_valid      in   1  Operand request valid.
//   in_ready      out  1  Ready to accept a request. High only in IDLE.
//   in_a          in   4  Multiplicand or dividend.
//   in_b          in   4  Multiplier or divisor.
//   in_op         in   2  00 = mulu, 01 = muls, 10 = divu, 11 = divs.
//   mul_a         out  4  To p08_mul4.a. Registered copy of latched in_a.
//   mul_b         out  4  To p08_mul4.b. Registered copy of latched in_b.
//   mul_opsigned  out  1  To p08_mul4.opsigned. Equals latched in_op[0].
//   mul_p         in   8  From p08_mul4.p. Combinational product.
//   out_valid     out  1  Result valid. High only in DONE.
//   out_ready     in   1  Consumer accepts the result.
//   out_result    out  8  Mul: product. Div: {remainder[3:0], quotient[3:0]}.
//   out_divzero   out  1  Set with a div result whose divisor was 0. Always 0 for mul.
// BEHAVIOUR
//   - Reset: state=IDLE. All registers clear to 0.
//     in_ready=1; out_valid=0; out_result=0; out_divzero=0; mul_a=mul_b=0; mul_opsigned=0.
//     Reset in any state, including mid-divide, abandons the operation and returns to IDLE.
//   - Accept happens on the edge where in_valid && in_ready. This latches in_a, in_b, in_op.
//     Next state: MUL if in_op[1]==0, else DIV.
//   - MUL, 1 cycle: the mul_* pins are stable from the accept edge.
//     At the end of MUL, out_result <= mul_p. Next state: DONE.
//     Latency: out_valid is high 2 edges after the accept edge.
//   - DIV, 4 cycles, restoring, MSB first, on magnitudes.
//     For signed ops, |a| and |b| are formed at accept.
//     Partial remainder is 5 bits wide.
//     A 2-bit counter runs 3..0; leave DIV after the count-0 cycle. Next state: FIX.
//   - FIX, 1 cycle: apply signs.
//     quotient negated if a[3]^b[3] (signed ops only).
//     remainder negated if a[3] (signed only); truncating division.
//     Next state: DONE. Latency: out_valid is high 6 edges after the accept edge.
//   - Division special cases:
//     b==0: quotient=4'hF, remainder=a (unmodified), out_divzero=1. Normal 6-edge latency.
//     divs a=-8, b=-1: quotient=4'h8, remainder=0. No overflow flag.
//   - DONE: out_valid=1. out_result and out_divzero hold stable while out_ready=0.
//     On out_valid && out_ready, next state is IDLE and out_valid drops next cycle.
//     in_ready rises on that same next cycle. No bypass: a new request can be accepted
//     at the earliest 1 edge after the result handshake.
//   - in_a, in_b, in_op are ignored outside IDLE. Changing them mid-operation has no effect.
//   - out_result keeps its last value in IDLE. It is only meaningful while out_valid=1.
// TESTING
//   1. Reset, then mulu a=F b=F -> out_valid on edge N+2; out_result=8'hE1; out_divzero=0.
//   2. muls a=8 b=8 -> 8'h40. Then muls a=3 b=E -> 8'hFA. Check mul_opsigned=1 during MUL.
//   3. divu a=D b=4 -> 8'h13 at edge N+6.
//      divs a=9 (-7) b=2 -> 8'hFD (q=-3, r=-1).
//      divs a=8 b=F -> 8'h08.
//   4. divu a=9 b=0 -> out_result=8'h9F, out_divzero=1, 6-edge latency.
//      divs a=9 b=0 -> 8'h9F, out_divzero=1.
//   5. Backpressure: hold out_ready=0 for 5 cycles in DONE.
//      Result and out_valid stay stable; in_ready stays 0; new in_valid is ignored.
//      Release out_ready -> IDLE; the next request is accepted 1 edge later.
//   6. Assert rst during DIV cycle 2 -> next cycle IDLE, in_ready=1, all outputs 0.
//      A following mulu 2x3 returns 8'h06.

Source files
------------

// File: rtl/muldiv4_seq.sv
// Handshaked sequencer around the external 4x4 multiplier, with a 4-cycle
// iterative restoring divider producing {remainder, quotient}.
module muldiv4_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   input  logic [1:0] in_op,
   output logic [3:0] mul_a,
   output logic [3:0] mul_b,
   output logic       mul_opsigned,
   input  logic [7:0] mul_p,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_result,
   output logic       out_divzero
);

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t     state, stateNext;
   logic [1:0] cnt;
   logic [3:0] rem, quo, dvs;
   logic       negQ, negR, divZero;

   logic       accept;
   logic [3:0] magA, magB, qFix, rFix;
   logic [4:0] part;
   logic [5:0] diff;
   logic       fits;

   assign accept    = in_valid && in_ready;
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Signed ops divide magnitudes; -8 maps to an unsigned 8, which is fine.
   assign magA = (in_op[0] && in_a[3]) ? (~in_a + 4'd1) : in_a;
   assign magB = (in_op[0] && in_b[3]) ? (~in_b + 4'd1) : in_b;

   // Shift next dividend bit into the partial remainder, then trial subtract.
   assign part = {rem, quo[3]};
   assign diff = {1'b0, part} - {2'b00, dvs};
   assign fits = ~diff[5];

   assign qFix = negQ ? (~quo + 4'd1) : quo;
   assign rFix = negR ? (~rem + 4'd1) : rem;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (accept) stateNext = in_op[1] ? DIV : MUL;
         MUL:  stateNext = DONE;
         DIV:  if (cnt == 2'd0) stateNext = FIX;
         FIX:  stateNext = DONE;
         DONE: if (out_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mul_a        <= '0;
         mul_b        <= '0;
         mul_opsigned <= 1'b0;
         out_result   <= '0;
         out_divzero  <= 1'b0;
         cnt          <= '0;
         rem          <= '0;
         quo          <= '0;
         dvs          <= '0;
         negQ         <= 1'b0;
         negR         <= 1'b0;
         divZero      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               mul_a        <= in_a;
               mul_b        <= in_b;
               mul_opsigned <= in_op[0];
               quo          <= magA;
               dvs          <= magB;
               rem          <= '0;
               cnt          <= 2'd3;
               negQ         <= in_op[0] & (in_a[3] ^ in_b[3]);
               negR         <= in_op[0] & in_a[3];
               divZero      <= (in_b == 4'd0);
            end
            MUL: begin
               out_result  <= mul_p;
               out_divzero <= 1'b0;
            end
            DIV: begin
               rem <= fits ? diff[3:0] : part[3:0];
               quo <= {quo[2:0], fits};
               cnt <= cnt - 2'd1;
            end
            FIX: begin
               // Divide-by-zero returns the raw dividend as remainder.
               out_divzero <= divZero;
               out_result  <= divZero ? {mul_a, 4'hF} : {rFix, qFix};
            end
            default: ;
         endcase
      end
   end

endmodule
